// File: rtl/pinball_pkg.sv
// Shared definitions for the pinball datapath blocks (ball sensor, game FSM,
// scorer, display driver).
//   - game state encodings (3-bit)
//   - datapath widths
//   - one double-dabble step used by the sequential binary-to-BCD converter
package pinball_pkg;

    typedef logic [2:0] game_state_t;

    localparam game_state_t ST_RESET = 3'd0;
    localparam game_state_t ST_WAIT  = 3'd1;
    localparam game_state_t ST_START = 3'd2;
    localparam game_state_t ST_GET   = 3'd3;
    localparam game_state_t ST_OVER  = 3'd4;

    localparam int NUM_HOLES = 8;
    localparam int SCORE_W   = 14;
    localparam int BCD_W     = 16;

    // Add 3 to every digit >= 5, then shift left bringing in the next binary bit.
    function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd,
                                                     input logic             in_bit);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int d = 0; d < BCD_W / 4; d++) begin
            if (adj[d*4 +: 4] >= 4'd5)
                adj[d*4 +: 4] = adj[d*4 +: 4] + 4'd3;
        end
        return {adj[BCD_W-2:0], in_bit};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, two lanes sharing one shift counter.
//   clk, rst_n     : clock, async active-low reset (aborts a conversion)
//   start          : load bin_a/bin_b and begin; honoured when idle or on done
//   bin_a, bin_b   : 14-bit binary inputs
//   bcd_a, bcd_b   : 4-digit BCD results, meaningful while done is high
//   done           : high in the cycle of the 14th shift; results are captured
//                    by the consumer at that edge (15 cycles after start)
module bin2bcd_seq
    import pinball_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin_a,
    input  logic [SCORE_W-1:0] bin_b,
    output logic [BCD_W-1:0]   bcd_a,
    output logic [BCD_W-1:0]   bcd_b,
    output logic               done
);

    logic [SCORE_W-1:0] sh_a, sh_b;
    logic [BCD_W-1:0]   acc_a, acc_b;
    logic [3:0]         cnt;
    logic               busy;

    assign done  = busy && (cnt == 4'(SCORE_W - 1));
    // Last shift is presented combinationally so the result lands one cycle earlier.
    assign bcd_a = dabble_step(acc_a, sh_a[SCORE_W-1]);
    assign bcd_b = dabble_step(acc_b, sh_b[SCORE_W-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a  <= '0;
            sh_b  <= '0;
            acc_a <= '0;
            acc_b <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start && (!busy || done)) begin
            sh_a  <= bin_a;
            sh_b  <= bin_b;
            acc_a <= '0;
            acc_b <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            acc_a <= dabble_step(acc_a, sh_a[SCORE_W-1]);
            acc_b <= dabble_step(acc_b, sh_b[SCORE_W-1]);
            sh_a  <= sh_a << 1;
            sh_b  <= sh_b << 1;
            cnt   <= cnt + 4'd1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/pinball_scorer.sv
// Pinball scorer: hole hits -> points with timed combo multiplier, saturating
// score, session high score and tear-free BCD copies for the display.
//   clk, rst_n            : clock, async active-low reset
//   state                 : game state (pinball_pkg encodings)
//   getball               : one-cycle hit pulses, bit i = hole i
//   score_bin, high_bin   : binary score / high score
//   score_bcd, high_bcd   : 4-digit BCD copies
//   bcd_valid             : BCD outputs match the binary values
//   mult                  : current multiplier 1..MAX_MULT
//   new_high              : one-cycle pulse when high_bin is updated
module pinball_scorer
    import pinball_pkg::*;
#(
    parameter logic [63:0] HOLE_PTS  = 64'h0A141E32321E140A,
    parameter int          COMBO_WIN = 100_000_000,
    parameter int          MAX_MULT  = 4,
    parameter int          SCORE_MAX = 9999
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         state,
    input  logic [7:0]         getball,
    output logic [SCORE_W-1:0] score_bin,
    output logic [SCORE_W-1:0] high_bin,
    output logic [BCD_W-1:0]   score_bcd,
    output logic [BCD_W-1:0]   high_bcd,
    output logic               bcd_valid,
    output logic [2:0]         mult,
    output logic               new_high
);

    localparam int TW = $clog2(COMBO_WIN + 1);

    logic [2:0]         hit_idx;
    logic               hit;
    logic [7:0]         pts;
    logic [10:0]        prod;
    logic [14:0]        sum;
    logic [SCORE_W-1:0] score_nxt;
    logic [TW-1:0]      timer;
    logic               active;    // a hit occurred and its window has not closed
    logic [2:0]         prev_state;

    // Lowest-index set bit wins.
    always_comb begin
        hit_idx = '0;
        for (int i = NUM_HOLES - 1; i >= 0; i--) begin
            if (getball[i])
                hit_idx = 3'(i);
        end
    end

    assign hit       = (state == ST_GET) && (getball != '0);
    assign pts       = HOLE_PTS[{hit_idx, 3'b000} +: 8];
    assign prod      = 11'(pts) * 11'(mult);
    assign sum       = 15'(score_bin) + 15'(prod);
    assign score_nxt = (sum > 15'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : sum[SCORE_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_bin  <= '0;
            high_bin   <= '0;
            mult       <= 3'd1;
            timer      <= '0;
            active     <= 1'b0;
            new_high   <= 1'b0;
            prev_state <= ST_RESET;
        end else begin
            prev_state <= state;
            new_high   <= 1'b0;
            if (state == ST_RESET) begin
                score_bin <= '0;
                mult      <= 3'd1;
                timer     <= '0;
                active    <= 1'b0;
            end else if (hit) begin
                score_bin <= score_nxt;
                if (active)
                    mult <= (mult >= 3'(MAX_MULT)) ? 3'(MAX_MULT) : mult + 3'd1;
                else
                    mult <= 3'd1;
                timer  <= TW'(COMBO_WIN);
                active <= 1'b1;
            end else if (active) begin
                // Window stays open through the cycle the timer reads 0.
                if (timer == '0) begin
                    active <= 1'b0;
                    mult   <= 3'd1;
                end else begin
                    timer <= timer - TW'(1);
                end
            end
            if (state == ST_OVER && prev_state != ST_OVER && score_bin > high_bin) begin
                high_bin <= score_bin;
                new_high <= 1'b1;
            end
        end
    end

    // BCD refresh control
    logic [SCORE_W-1:0] score_d, high_d;
    logic               req;        // a binary change was seen last cycle
    logic               pending;    // change arrived while converting
    logic               in_flight;
    logic               accept;
    logic               cv_done;
    logic [BCD_W-1:0]   cv_score, cv_high;

    assign accept    = (req || pending) && (!in_flight || cv_done);
    assign bcd_valid = !(req || pending || in_flight);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_d   <= '0;
            high_d    <= '0;
            req       <= 1'b0;
            pending   <= 1'b0;
            in_flight <= 1'b0;
            score_bcd <= '0;
            high_bcd  <= '0;
        end else begin
            score_d <= score_bin;
            high_d  <= high_bin;
            req     <= (score_bin != score_d) || (high_bin != high_d);
            if (accept)
                pending <= 1'b0;
            else if (req)
                pending <= 1'b1;
            if (accept)
                in_flight <= 1'b1;
            else if (cv_done)
                in_flight <= 1'b0;
            // A stale result is discarded so both outputs always move together.
            if (cv_done && !pending && !req) begin
                score_bcd <= cv_score;
                high_bcd  <= cv_high;
            end
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept),
        .bin_a (score_bin),
        .bin_b (high_bin),
        .bcd_a (cv_score),
        .bcd_b (cv_high),
        .done  (cv_done)
    );

endmodule

// File: tb/tb_pinball_scorer.sv
// Directed bench for pinball_scorer (COMBO_WIN shortened to 20 cycles).
module tb_pinball_scorer;
    import pinball_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  state;
    logic [7:0]  getball;
    logic [13:0] score_bin, high_bin;
    logic [15:0] score_bcd, high_bcd;
    logic        bcd_valid, new_high;
    logic [2:0]  mult;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pinball_scorer #(.COMBO_WIN(20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .state     (state),
        .getball   (getball),
        .score_bin (score_bin),
        .high_bin  (high_bin),
        .score_bcd (score_bcd),
        .high_bcd  (high_bcd),
        .bcd_valid (bcd_valid),
        .mult      (mult),
        .new_high  (new_high)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitn(input int n);
        repeat (n) tick();
    endtask

    task automatic hit(input logic [7:0] m);
        getball = m;
        tick();
        getball = 8'h00;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " score"}, 32'(score_bin), 32'd0);
        check({tag, " high"},  32'(high_bin),  32'd0);
        check({tag, " sbcd"},  32'(score_bcd), 32'h0);
        check({tag, " hbcd"},  32'(high_bcd),  32'h0);
        check({tag, " valid"}, 32'(bcd_valid), 32'd1);
        check({tag, " mult"},  32'(mult),      32'd1);
        check({tag, " newhi"}, 32'(new_high),  32'd0);
    endtask

    initial begin
        state   = ST_RESET;
        getball = 8'h00;
        #12;
        check_reset_vals("por");
        rst_n = 1'b1;
        tick();
        state = ST_GET;
        tick();

        // single hit on hole 3 and its BCD latency
        hit(8'h08);
        check("a score", 32'(score_bin), 32'd50);
        check("a mult",  32'(mult),      32'd1);
        check("a valid1", 32'(bcd_valid), 32'd1);
        waitn(15);
        check("a valid16", 32'(bcd_valid), 32'd0);
        check("a bcd16",   32'(score_bcd), 32'h0000);
        waitn(1);
        check("a valid17", 32'(bcd_valid), 32'd1);
        check("a bcd17",   32'(score_bcd), 32'h0050);

        // async reset during a conversion
        hit(8'h08);
        waitn(4);
        rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        rst_n = 1'b1;
        tick();

        // combo chain
        hit(8'h08);
        check("b s0", 32'(score_bin), 32'd50);
        waitn(9);
        hit(8'h01);
        check("b s1", 32'(score_bin), 32'd60);
        check("b m1", 32'(mult),      32'd2);
        waitn(4);
        hit(8'h02);
        check("b s2", 32'(score_bin), 32'd100);
        check("b m2", 32'(mult),      32'd3);
        check("b notear bcd", 32'(score_bcd), 32'h0000);
        check("b notear vld", 32'(bcd_valid), 32'd0);
        waitn(20);
        hit(8'h01);  // timer reads 0 here: still inside the window
        check("b edge s", 32'(score_bin), 32'd130);
        check("b edge m", 32'(mult),      32'd4);
        waitn(20);
        check("b m hold", 32'(mult), 32'd4);
        waitn(1);
        check("b m expire", 32'(mult), 32'd1);
        waitn(10);
        check("b bcd", 32'(score_bcd), 32'h0130);
        check("b vld", 32'(bcd_valid), 32'd1);

        // RESET state and expired window
        state = ST_RESET;
        waitn(2);
        check("c rst score", 32'(score_bin), 32'd0);
        check("c rst mult",  32'(mult),      32'd1);
        state = ST_GET;
        hit(8'h01);
        waitn(25);
        check("c m gap", 32'(mult), 32'd1);
        hit(8'h01);
        check("c s", 32'(score_bin), 32'd20);
        check("c m", 32'(mult),      32'd1);

        // priority and state gating
        state = ST_RESET;
        tick();
        state = ST_GET;
        hit(8'h24);
        check("d get", 32'(score_bin), 32'd30);
        state = ST_WAIT;
        hit(8'h24);
        check("d wait", 32'(score_bin), 32'd30);
        state = ST_START;
        hit(8'h24);
        check("d start", 32'(score_bin), 32'd30);

        // saturation, high score, RESET keeps high
        state = ST_RESET;
        tick();
        state = ST_GET;
        repeat (60) hit(8'h08);
        check("e sat", 32'(score_bin), 32'd9999);
        check("e mult", 32'(mult), 32'd4);
        waitn(40);
        check("e sbcd", 32'(score_bcd), 32'h9999);
        check("e vld",  32'(bcd_valid), 32'd1);
        state = ST_OVER;
        tick();
        check("e high", 32'(high_bin), 32'd9999);
        check("e nh1",  32'(new_high), 32'd1);
        tick();
        check("e nh2",  32'(new_high), 32'd0);
        state = ST_RESET;
        waitn(2);
        check("e rst score", 32'(score_bin), 32'd0);
        check("e rst high",  32'(high_bin),  32'd9999);
        waitn(40);
        check("e hbcd",  32'(high_bcd),  32'h9999);
        check("e sbcd0", 32'(score_bcd), 32'h0000);
        state = ST_GET;
        hit(8'h08);
        state = ST_OVER;
        tick();
        check("e low nh", 32'(new_high), 32'd0);
        check("e low hi", 32'(high_bin), 32'd9999);

        rst_n = 1'b0;
        #1;
        check("f arst high", 32'(high_bin), 32'd0);
        check("f arst hbcd", 32'(high_bcd), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pinball_scorer.md
Name: pinball_scorer

Overview:
- Sits directly downstream of the ball sensor stage.
- Consumes the per-hole one-pulse vector `getball` and the game `state`.
- Converts hole hits into points with a timed combo multiplier and accumulates a saturating score.
- Tracks the session high score and emits BCD copies of both scores for the seven-segment display driver.

Parameters:
- HOLE_PTS, 64'h0A141E32321E140A, byte i = points for hole i (default holes 0..7 = 10,20,30,50,50,30,20,10).
- COMBO_WIN, 100_000_000, cycles after a hit during which the next hit raises the multiplier.
- MAX_MULT, 4, multiplier ceiling (range 1..7).
- SCORE_MAX, 9999, saturation value of score and high score.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- state  input  3  game state: RESET=0, WAIT=1, START=2, GET=3, OVER=4
- getball  input  8  one-cycle hit pulses, bit i = hole i
- score_bin  output  14  current score, binary
- high_bin  output  14  high score, binary
- score_bcd  output  16  current score, 4 BCD digits, [15:12] = thousands
- high_bcd  output  16  high score, 4 BCD digits
- bcd_valid  output  1  high when both BCD outputs reflect the current binary values
- mult  output  3  current multiplier (1..MAX_MULT)
- new_high  output  1  one-cycle pulse when the high score is updated

Behaviour:
Reset (rst_n low, async):
- score_bin=0, high_bin=0, score_bcd=0, high_bcd=0, bcd_valid=1, mult=1, new_high=0.
- Combo timer cleared; converter idle.
- rst_n asserted mid-conversion aborts the conversion immediately.

Hit selection:
- getball is sampled only while state==GET; pulses in any other state are ignored.
- If several bits are set in one cycle, only the lowest-index set bit scores; the others are dropped.
- This matches the sensor counting one ball per cycle.

Scoring (hit in cycle N):
- In cycle N+1: score_bin = min(score_bin + HOLE_PTS[i]*mult, SCORE_MAX).
- Product is 11 bits wide (max 255*7); the sum is formed at 15 bits before clamping.
- mult used is the value before the hit.
- In cycle N+1 mult becomes min(mult+1, MAX_MULT) if the previous hit occurred within COMBO_WIN cycles. Otherwise mult stays 1.
- Combo timer is reloaded to COMBO_WIN on every hit and decrements every cycle.
- When the timer reaches 0, mult returns to 1 on the following cycle.
- A hit on the same cycle the timer expires counts as inside the window.

State effects:
- state==RESET: score_bin=0, mult=1, timer=0 every cycle. high_bin is retained.
- First cycle of state==OVER (edge-detected from the previous state): if score_bin > high_bin, high_bin=score_bin on the next cycle and new_high pulses for that one cycle.
- WAIT and START: registers hold.

BCD conversion:
- Sequential double-dabble, one shift per cycle, 14 shifts.
- A conversion starts on the cycle after either score_bin or high_bin changes.
- score_bcd and high_bcd update together, exactly 15 cycles after the start.
- bcd_valid drops on the cycle after any binary change and rises together with the updated BCD outputs.
- A change arriving during a conversion sets a pending flag. The current conversion completes without driving the BCD outputs, then restarts immediately with the latest values.
- BCD outputs are never torn.

Decomposition:
- Shared package `pinball_pkg`: state encodings RESET/WAIT/START/GET/OVER (3-bit), NUM_HOLES=8, SCORE_W=14, BCD_W=16.
- The ball sensor, game FSM and display driver import the same package.
- Sub-module `bin2bcd_seq`:
  - inputs: clk, rst_n, start, 14-bit value pair;
  - outputs: two 16-bit BCD results, done;
  - 15-cycle latency, one conversion at a time.
- The scorer instantiates `bin2bcd_seq` once, converting score and high score in parallel lanes.

Test Plan:
- rst_n low mid-game and during a conversion -> all outputs at reset values asynchronously; high_bin=0; bcd_valid=1.
- COMBO_WIN=20, state=GET, getball=8'h08 at cycle 0 -> score_bin=50 and mult=1 at cycle 1; score_bcd=16'h0050 and bcd_valid=1 by cycle 17.
- Same setup, then getball=8'h01 at cycle 10 and 8'h02 at cycle 15 -> score_bin 50 -> 60 (10*1) -> 100 (20*2). mult reads 2 then 3.
- Hit hole 0, wait 25 cycles with COMBO_WIN=20, hit hole 0 -> mult back to 1 before the second hit; score_bin=20.
- getball=8'h24 in GET -> only hole 2 scores (+30). The same pulse in WAIT or START -> no change.
- Repeated hole-3 hits until saturation -> score_bin clamps at 9999 (score_bcd=16'h9999). Enter OVER with high_bin=0 -> high_bin=9999 and one new_high pulse. Return to RESET -> score_bin=0, high_bin holds 9999.
